id_scoreboard_ctrl: RTL and testbench
=====================================

Name: id_scoreboard_ctrl

Overview:
Issue controller for the instruction-decode stage. It tracks destination registers with in-flight writes in a per-register pending scoreboard. It stalls decode on RAW/WAW hazards, on outstanding-write overflow and on fence drain, and issues the decoded instruction to execute with a valid/ready handshake. It sits between inst_decode/reg_file and the EX stage and consumes the writeback retire stream that drives the reg_file write port.

Parameters:
NREG, 32, number of architectural registers (x0 hard-wired zero)
AW, 5, register index width, equals clog2(NREG)
MAX_OUT, 8, maximum outstanding register-writing instructions
CNT_W, 32, stall performance counter width

Ports:
clk  input  1  core clock
rst_n  input  1  reset, asynchronous, active-low
id_valid  input  1  decoded instruction present in ID
id_rs1  input  AW  source 1 index
id_rs2  input  AW  source 2 index
id_rd  input  AW  destination index
id_uses_rs1  input  1  instruction reads rs1
id_uses_rs2  input  1  instruction reads rs2
id_writes_rd  input  1  instruction writes rd
id_fence  input  1  instruction must wait for all outstanding writes
ex_ready  input  1  EX stage accepts an instruction this cycle
flush  input  1  kill instruction currently in ID
wb_valid  input  1  retire pulse for one previously issued writing instruction
wb_rd  input  AW  destination of retiring instruction
id_ready  output  1  ID may advance (instruction consumed or none present)
issue  output  1  instruction handed to EX this cycle
stall  output  1  id_valid held by hazard/drain
pending_vec  output  NREG  scoreboard contents
out_cnt  output  clog2(MAX_OUT)+1  outstanding writing instructions
stall_cycles  output  CNT_W  saturating count of stall cycles
sb_err  output  1  sticky protocol error

Behaviour:
- Reset: async on rst_n low. pending_vec=0, out_cnt=0, stall_cycles=0, sb_err=0, FSM=RUN, issue=0, stall=0, id_ready=1.
- Effective pending per register: pend_eff[r] = pending_vec[r] & ~(wb_valid & wb_rd==r). Writeback in the same cycle resolves the hazard; reg_file is write-before-read.
- Index 0 is never pending. Issues with rd=0 do not set a bit and do not count toward out_cnt.
- hazard = (uses_rs1 & pend_eff[rs1]) | (uses_rs2 & pend_eff[rs2]) | (writes_rd & rd!=0 & pend_eff[rd]) | (writes_rd & rd!=0 & out_cnt_eff==MAX_OUT). out_cnt_eff is out_cnt minus the same-cycle retire.
- FSM states RUN, STALL, DRAIN. Decisions are combinational from the current state and inputs; the state register updates at the clock edge.
  - RUN: if id_valid & ~flush & id_fence & out_cnt_eff!=0, go to DRAIN. Else if id_valid & ~flush & hazard, go to STALL. Else, if id_valid & ~flush & ex_ready, issue=1.
  - STALL: re-evaluate hazard every cycle. When it clears, issue in that same cycle if ex_ready and return to RUN.
  - DRAIN: wait for out_cnt_eff==0, then issue the fence if ex_ready and go to RUN.
  - flush from any state: go to RUN, issue=0, scoreboard untouched.
- stall = id_valid & ~flush & (hazard | (fence & out_cnt_eff!=0)).
- id_ready = ~id_valid | flush | issue.
- ex_ready low with no hazard is backpressure, not a stall: stall=0 and the FSM stays in its current state.
- On issue with writes_rd & rd!=0: pending_vec[rd] is set at the next edge and out_cnt increments.
- On wb_valid with wb_rd!=0: pending_vec[wb_rd] is cleared and out_cnt decrements.
- Same-cycle issue and retire: out_cnt is unchanged. For the same register, the retire clears first and then the issue sets, so the bit ends at 1.
- wb_valid with wb_rd=0: ignored.
- Every issued writing instruction, including ones later squashed, produces exactly one wb_valid.
- sb_err is set (sticky until reset) on:
  - wb_valid for a non-pending nonzero register
  - out_cnt underflow
  - out_cnt overflow
  In all three cases the counter is not modified.
- stall_cycles increments on each cycle with stall=1 and saturates at all-ones.
- Issue latency: 0 cycles when there is no hazard. Minimum load-use style stall is 1 cycle per outstanding producer.

Decomposition:
- Shared package: the FSM state enum (RUN/STALL/DRAIN), AW/NREG constants, and the x0 index constant. Reuse the constants in reg_file and inst_decode.
- One natural sub-module, sb_pending_table: the pending bit vector with the set/clear ports, the x0 mask, and the pend_eff bypass lookups for three read indices.
- The FSM, counters and error logic live in the top module.

Test Plan:
- Issue x5 writer, next cycle reader of rs1=x5 with no wb: stall=1, issue=0, stall_cycles increments. Assert wb_valid rd=5: issue=1 that same cycle, pending_vec[5]=0 then 1 only if the reader writes x5.
- WAW: writer rd=7 pending, second writer rd=7: stall until wb rd=7. Same-cycle retire plus issue leaves pending_vec[7]=1 and out_cnt unchanged.
- Fill 8 writers to x1..x8 (out_cnt=8), 9th writer rd=9: stall. One retire then issues the 9th in that cycle, out_cnt stays 8.
- Fence with out_cnt=3: DRAIN. After 3 retires the fence issues on the cycle out_cnt_eff hits 0; FSM returns to RUN.
- flush during STALL: issue=0, id_ready=1, FSM goes to RUN, pending_vec unchanged. Spurious wb_valid rd=12 with no pending bit: sb_err=1, out_cnt unchanged.
- rst_n asserted low mid-DRAIN with out_cnt=4: all outputs reset immediately (async). Writer rd=0 issues with no scoreboard change.

Source files
------------

// File: rtl/id_scoreboard_ctrl_pkg.sv
// Shared definitions for the ID-stage issue controller.
// The register-file geometry (NREG_C, AW_C, X0_IDX) is meant to be reused by
// reg_file and inst_decode, so that all three blocks agree on the x0 index.
// The package also holds the outstanding-write limit, the width of the stall
// counter and the issue FSM state encoding.
package id_scoreboard_ctrl_pkg;

  localparam int NREG_C    = 32;
  localparam int AW_C      = 5;
  localparam int MAX_OUT_C = 8;
  localparam int CNT_W_C   = 32;

  // Index of the hard-wired zero register.
  localparam logic [AW_C-1:0] X0_IDX = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_DRAIN = 2'd2
  } sb_state_e;

endpackage

// File: rtl/id_scoreboard_ctrl_sb_pending_table.sv
// sb_pending_table: a pending bit for each architectural register.
// Ports:
//   set_en/set_idx     mark a register as having a write in flight
//                      (the register is issued this cycle)
//   clr_en/clr_idx     retire a write (writeback this cycle)
//   rd_idx_a/b/c       three lookups that return the effective pending bit.
//                      A writeback in the same cycle is bypassed.
//   pend_raw_clr       the stored bit at clr_idx, without the bypass
//   pending_vec        the stored table; bit 0 always reads 0
module sb_pending_table
  import id_scoreboard_ctrl_pkg::*;
#(
  parameter int NREG = NREG_C,
  parameter int AW   = AW_C
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_en,
  input  logic [AW-1:0]   set_idx,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_idx,
  input  logic [AW-1:0]   rd_idx_a,
  input  logic [AW-1:0]   rd_idx_b,
  input  logic [AW-1:0]   rd_idx_c,
  output logic [NREG-1:0] pending_vec,
  output logic            pend_eff_a,
  output logic            pend_eff_b,
  output logic            pend_eff_c,
  output logic            pend_raw_clr
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  // Decode set/clear masks and build the next table: the clear is applied
  // before the set, so a retire and an issue to the same register leave it pending.
  always_comb begin
    set_mask = {NREG{1'b0}};
    clr_mask = {NREG{1'b0}};
    for (int r = 0; r < NREG; r++) begin
      set_mask[r] = set_en & (set_idx == AW'(r));
      clr_mask[r] = clr_en & (clr_idx == AW'(r));
    end
    pending_d    = (pending_q & ~clr_mask) | set_mask;
    pending_d[0] = 1'b0;
  end

  // Effective pending lookups; the register file is write-before-read.
  always_comb begin
    pend_eff_a   = pending_q[rd_idx_a] & ~clr_mask[rd_idx_a];
    pend_eff_b   = pending_q[rd_idx_b] & ~clr_mask[rd_idx_b];
    pend_eff_c   = pending_q[rd_idx_c] & ~clr_mask[rd_idx_c];
    pend_raw_clr = pending_q[clr_idx];
  end

  // Pending table register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= {NREG{1'b0}};
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_vec = pending_q;

endmodule

// File: rtl/id_scoreboard_ctrl.sv
// id_scoreboard_ctrl: issue controller for the instruction-decode (ID) stage.
// It holds back the decoded instruction on these conditions:
//   - RAW and WAW hazards against the pending table;
//   - the outstanding-write limit has been reached;
//   - a fence is waiting for earlier writes to drain.
// Otherwise it hands the instruction to EX in the same cycle.
// Ports:
//   id_*           decoded instruction from ID
//   ex_ready       EX can accept an instruction
//   flush          kills the instruction that is in ID
//   wb_valid/wb_rd retire stream from writeback
//   id_ready/issue/stall
//                  combinational handshake and status
//   pending_vec, out_cnt, stall_cycles, sb_err
//                  registered scoreboard state and error status
module id_scoreboard_ctrl
  import id_scoreboard_ctrl_pkg::*;
#(
  parameter int NREG    = NREG_C,
  parameter int AW      = AW_C,
  parameter int MAX_OUT = MAX_OUT_C,
  parameter int CNT_W   = CNT_W_C,
  parameter int OW      = $clog2(MAX_OUT) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs1,
  input  logic [AW-1:0]   id_rs2,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic            id_writes_rd,
  input  logic            id_fence,
  input  logic            ex_ready,
  input  logic            flush,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  output logic            id_ready,
  output logic            issue,
  output logic            stall,
  output logic [NREG-1:0] pending_vec,
  output logic [OW-1:0]   out_cnt,
  output logic [CNT_W-1:0] stall_cycles,
  output logic            sb_err
);

  sb_state_e        state_q, state_d;
  logic [OW-1:0]    out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic             sb_err_q, sb_err_d;

  logic pend_eff_rs1, pend_eff_rs2, pend_eff_rd, pend_raw_wb;
  logic rd_nz, wb_nz;
  logic ret_ok, spurious_wb, dec_ok, underflow, overflow, inc_req, set_en;
  logic hazard, fence_block, live;
  logic [OW-1:0] out_cnt_eff;

  sb_pending_table #(
    .NREG (NREG),
    .AW   (AW)
  ) u_pending (
    .clk          (clk),
    .rst_n        (rst_n),
    .set_en       (set_en),
    .set_idx      (id_rd),
    .clr_en       (wb_valid),
    .clr_idx      (wb_rd),
    .rd_idx_a     (id_rs1),
    .rd_idx_b     (id_rs2),
    .rd_idx_c     (id_rd),
    .pending_vec  (pending_vec),
    .pend_eff_a   (pend_eff_rs1),
    .pend_eff_b   (pend_eff_rs2),
    .pend_eff_c   (pend_eff_rd),
    .pend_raw_clr (pend_raw_wb)
  );

  // Retire qualification, hazard detection and the issue handshake.
  always_comb begin
    rd_nz       = (id_rd != {AW{1'b0}});
    wb_nz       = (wb_rd != {AW{1'b0}});
    ret_ok      = wb_valid & wb_nz & pend_raw_wb;
    spurious_wb = wb_valid & wb_nz & ~pend_raw_wb;
    // A retire with a zero counter would underflow; that retire is not counted.
    dec_ok      = ret_ok & (out_cnt_q != {OW{1'b0}});
    underflow   = ret_ok & (out_cnt_q == {OW{1'b0}});
    out_cnt_eff = out_cnt_q - {{(OW-1){1'b0}}, dec_ok};

    hazard = (id_uses_rs1 & pend_eff_rs1)
           | (id_uses_rs2 & pend_eff_rs2)
           | (id_writes_rd & rd_nz & pend_eff_rd)
           | (id_writes_rd & rd_nz & (out_cnt_eff == OW'(MAX_OUT)));
    fence_block = id_fence & (out_cnt_eff != {OW{1'b0}});
    live        = id_valid & ~flush;

    issue    = live & ~hazard & ~fence_block & ex_ready;
    stall    = live & (hazard | fence_block);
    id_ready = ~id_valid | flush | issue;

    inc_req  = issue & id_writes_rd & rd_nz;
    // The hazard term already blocks an issue at the limit; this check only
    // guards the counter against wrapping.
    overflow = inc_req & ~dec_ok & (out_cnt_q == OW'(MAX_OUT));
    set_en   = inc_req & ~overflow;
  end

  // Update the outstanding-write counter, the error flag and the stall counter.
  always_comb begin
    out_cnt_d = out_cnt_q;
    case ({set_en, dec_ok})
      2'b10:   out_cnt_d = out_cnt_q + {{(OW-1){1'b0}}, 1'b1};
      2'b01:   out_cnt_d = out_cnt_q - {{(OW-1){1'b0}}, 1'b1};
      default: out_cnt_d = out_cnt_q;
    endcase

    sb_err_d = sb_err_q | spurious_wb | underflow | overflow;

    if (stall && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // Issue FSM next state: a fence drain takes priority over a hazard, and
  // backpressure alone keeps the current state.
  always_comb begin
    state_d = state_q;
    if (flush || !id_valid) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (fence_block) begin
            state_d = ST_DRAIN;
          end else if (hazard) begin
            state_d = ST_STALL;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_STALL, ST_DRAIN: begin
          if (fence_block) begin
            state_d = ST_DRAIN;
          end else if (hazard) begin
            state_d = ST_STALL;
          end else if (issue) begin
            state_d = ST_RUN;
          end else begin
            state_d = state_q;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // State, counter and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      out_cnt_q      <= {OW{1'b0}};
      stall_cycles_q <= {CNT_W{1'b0}};
      sb_err_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      out_cnt_q      <= out_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      sb_err_q       <= sb_err_d;
    end
  end

  assign out_cnt      = out_cnt_q;
  assign stall_cycles = stall_cycles_q;
  assign sb_err       = sb_err_q;

endmodule

// File: tb/tb_id_scoreboard_ctrl.sv
module tb_id_scoreboard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_uses_rs1, id_uses_rs2, id_writes_rd, id_fence;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic        ex_ready, flush, wb_valid;
  logic        id_ready, issue, stall, sb_err;
  logic [31:0] pending_vec;
  logic [3:0]  out_cnt;
  logic [31:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        issue;
    logic        stall;
    logic        rdy;
    logic [31:0] pend;
    logic [3:0]  cnt;
    logic        err;
    logic [31:0] sc;
  } exp_t;

  exp_t exp_q[$];

  // reference model state
  logic [31:0] m_pend = 32'd0;
  int          m_cnt  = 0;
  logic        m_err  = 1'b0;
  logic [31:0] m_sc   = 32'd0;

  always #5 clk = ~clk;

  id_scoreboard_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .id_writes_rd (id_writes_rd),
    .id_fence     (id_fence),
    .ex_ready     (ex_ready),
    .flush        (flush),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .id_ready     (id_ready),
    .issue        (issue),
    .stall        (stall),
    .pending_vec  (pending_vec),
    .out_cnt      (out_cnt),
    .stall_cycles (stall_cycles),
    .sb_err       (sb_err)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, predict, compare 1ns later, advance the model.
  task automatic step(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic u1, input logic u2,
                      input logic w, input logic f, input logic exr, input logic fl,
                      input logic wbv, input logic [4:0] wbrd);
    exp_t e;
    logic [31:0] clrm, peff;
    logic rok, haz, fblk, iss, inc;
    int ce;
    @(negedge clk);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_writes_rd = w; id_fence = f;
    ex_ready = exr; flush = fl; wb_valid = wbv; wb_rd = wbrd;

    clrm = (wbv && wbrd != 5'd0) ? (32'd1 << wbrd) : 32'd0;
    peff = m_pend & ~clrm;
    rok  = wbv && wbrd != 5'd0 && m_pend[wbrd];
    ce   = m_cnt - ((rok && m_cnt > 0) ? 1 : 0);
    haz  = (u1 && peff[rs1]) || (u2 && peff[rs2]) ||
           (w && rd != 5'd0 && peff[rd]) || (w && rd != 5'd0 && ce == 8);
    fblk = f && ce != 0;
    iss  = v && !fl && !haz && !fblk && exr;
    e.issue = iss;
    e.stall = v && !fl && (haz || fblk);
    e.rdy   = !v || fl || iss;
    e.pend  = m_pend;
    e.cnt   = 4'(m_cnt);
    e.err   = m_err;
    e.sc    = m_sc;
    exp_q.push_back(e);

    #1;
    e = exp_q.pop_front();
    chk("issue",        64'(issue),        64'(e.issue));
    chk("stall",        64'(stall),        64'(e.stall));
    chk("id_ready",     64'(id_ready),     64'(e.rdy));
    chk("pending_vec",  64'(pending_vec),  64'(e.pend));
    chk("out_cnt",      64'(out_cnt),      64'(e.cnt));
    chk("sb_err",       64'(sb_err),       64'(e.err));
    chk("stall_cycles", 64'(stall_cycles), 64'(e.sc));

    inc = iss && w && rd != 5'd0;
    if (wbv && wbrd != 5'd0 && !m_pend[wbrd]) m_err = 1'b1;
    m_pend = (m_pend & ~clrm) | (inc ? (32'd1 << rd) : 32'd0);
    m_cnt  = m_cnt + (inc ? 1 : 0) - ((rok && m_cnt > 0) ? 1 : 0);
    if (e.stall && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
  endtask

  task automatic idle(input logic wbv, input logic [4:0] wbrd);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, wbv, wbrd);
  endtask

  task automatic wr(input logic [4:0] rd);
    step(1'b1, 5'd0, 5'd0, rd, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic fence_step(input logic wbv, input logic [4:0] wbrd);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, wbv, wbrd);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_pend"},  64'(pending_vec),  64'd0);
    chk({tag, "_cnt"},   64'(out_cnt),      64'd0);
    chk({tag, "_sc"},    64'(stall_cycles), 64'd0);
    chk({tag, "_err"},   64'(sb_err),       64'd0);
    chk({tag, "_issue"}, 64'(issue),        64'd0);
    chk({tag, "_stall"}, 64'(stall),        64'd0);
    chk({tag, "_rdy"},   64'(id_ready),     64'd1);
  endtask

  task automatic model_reset();
    m_pend = 32'd0; m_cnt = 0; m_err = 1'b0; m_sc = 32'd0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] pick;
    rst_n = 1'b0;
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_writes_rd = 1'b0; id_fence = 1'b0;
    ex_ready = 1'b1; flush = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0;
    #12;
    reset_checks("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // RAW: x5 writer, then a reader of x5 that also writes x5
    wr(5'd5);
    step(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    step(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    step(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5);
    chk("raw_issue_on_wb", 64'(issue), 64'd1);
    idle(1'b0, 5'd0);
    chk("raw_pend5", 64'(pending_vec[5]), 64'd1);
    chk("raw_stalls", 64'(stall_cycles), 64'd2);
    idle(1'b1, 5'd5);

    // WAW on x7, then a retire and an issue of x7 in the same cycle
    wr(5'd7);
    step(1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    step(1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7);
    idle(1'b0, 5'd0);
    chk("waw_pend7", 64'(pending_vec[7]), 64'd1);
    chk("waw_cnt", 64'(out_cnt), 64'd1);
    idle(1'b1, 5'd7);

    // Fill to MAX_OUT, ninth writer stalls, issues on a retire
    for (int r = 1; r <= 8; r++) wr(5'(r));
    wr(5'd9);
    step(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1);
    idle(1'b0, 5'd0);
    chk("full_cnt", 64'(out_cnt), 64'd8);
    for (int r = 2; r <= 9; r++) idle(1'b1, 5'(r));

    // Fence drains three outstanding writes
    wr(5'd10); wr(5'd11); wr(5'd13);
    fence_step(1'b0, 5'd0);
    fence_step(1'b1, 5'd10);
    fence_step(1'b1, 5'd11);
    fence_step(1'b1, 5'd13);
    chk("fence_issue", 64'(issue), 64'd1);
    step(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    // backpressure without hazard
    step(1'b1, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b1, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3);
    idle(1'b1, 5'd4);

    // Flush during stall, then a spurious writeback
    wr(5'd14);
    step(1'b1, 5'd0, 5'd14, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    step(1'b1, 5'd0, 5'd14, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0);
    idle(1'b0, 5'd0);
    chk("flush_pend14", 64'(pending_vec[14]), 64'd1);
    idle(1'b1, 5'd12);
    idle(1'b0, 5'd0);
    chk("spur_err", 64'(sb_err), 64'd1);
    chk("spur_cnt", 64'(out_cnt), 64'd1);
    idle(1'b1, 5'd14);

    // Async reset while draining with four outstanding writes
    for (int r = 1; r <= 4; r++) wr(5'(r));
    fence_step(1'b0, 5'd0);
    chk("drain_cnt", 64'(out_cnt), 64'd4);
    #2;
    id_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    reset_checks("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Writer to x0 issues without touching the scoreboard
    wr(5'd0);
    chk("x0_issue", 64'(issue), 64'd1);
    idle(1'b0, 5'd0);
    chk("x0_pend", 64'(pending_vec), 64'd0);
    chk("x0_cnt", 64'(out_cnt), 64'd0);

    // Random traffic; writebacks only retire pending registers
    for (int i = 0; i < 300; i++) begin
      logic wbv;
      wbv  = 1'b0;
      pick = 5'd0;
      if (m_pend != 32'd0 && $urandom_range(0, 1) == 1) begin
        int s;
        s = $urandom_range(1, 31);
        for (int k = 0; k < 32; k++) begin
          if (!wbv && m_pend[(s + k) % 32]) begin
            wbv  = 1'b1;
            pick = 5'((s + k) % 32);
          end
        end
      end
      step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 15)),
           5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
           wbv, pick);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
